avalon_st_pattern_gen: RTL and testbench
========================================

# avalon_st_pattern_gen

Parametrised Avalon-ST traffic generator: the next generation of our ramp-only stream source, with selectable lane width, pattern mode, packet framing (SOP/EOP), inter-beat gap throttling, continuous or fixed-length runs and a graceful stop. It sits on the Avalon-MM control bus next to the other test IP and drives a streaming sink such as a DMA, FIFO or checker. Software programs it, pulses start, and polls status and the beat counter.

## Interface
- DATA_W, 256: stream data width in bits; must be a multiple of SAMP_W.
- SAMP_W, 16: lane (sample) width in bits; NR_LANES = DATA_W/SAMP_W.
- csi_clk_clk  in  1  sole clock; all logic on its rising edge.
- rsi_reset_reset  in  1  reset, synchronous, active-high.
- avs_ctrl_address  in  4  word address.
- avs_ctrl_read  in  1  read strobe.
- avs_ctrl_write  in  1  write strobe.
- avs_ctrl_readdata  out  32  read data, fixed read latency 1.
- avs_ctrl_writedata  in  32  write data.
- aso_data_data  out  DATA_W  lane i at bits [i*SAMP_W +: SAMP_W].
- aso_data_valid  out  1  beat valid.
- aso_data_ready  in  1  sink ready, ready latency 0.
- aso_data_startofpacket  out  1  first beat of packet.
- aso_data_endofpacket  out  1  last beat of packet.

## Operation
- Register map (R = read, W = write):
  - 0 R: ID 0xa51579e3.
  - 1 R: version 0x00000300.
  - 2 R: DATA_W.
  - 3 RW: scratch.
  - 4 R: status; bit0 busy, bit1 stop_pending.
  - 5 W: control; bit0 start, bit1 stop. Self-clearing one-cycle pulses; reads return 0.
  - 6 RW: mode[1:0]. 0 = ramp, 1 = constant, 2 = beat index, 3 = reserved (behaves as ramp).
  - 7 RW: pkt_len, beats per packet; 0 is treated as 1.
  - 8 RW: total_beats; 0 = continuous.
  - 9 R: beats_sent, 32 bits.
  - 10 RW: gap[7:0], idle cycles inserted after every accepted beat.
  - 11 RW: const_val[SAMP_W-1:0].
  - Other addresses read 0xdeadbeef.
- Config registers reset to 0 and are freely writable. Mode, pkt_len, total_beats, gap and const_val are latched into working copies on start, so writes during a run do not affect that run.
- States and transitions:
  - IDLE: valid = 0. On start → SEND.
  - SEND: valid = 1. When a beat is accepted (valid & ready): if it is the final beat, or it carries EOP while stop_pending is set → IDLE; else if gap > 0 → GAP; else stay in SEND.
  - GAP: valid = 0 and a gap counter decrements each cycle; when it reaches 0 → SEND.
- Start while busy is ignored. Stop in IDLE is ignored.
- Stop while busy sets stop_pending; the run ends after the next EOP beat is accepted. stop_pending clears on entry to IDLE.
- Start and stop written in the same word: start wins if IDLE, stop wins if busy.
- Final beat: beats_sent + 1 == total_beats, when total_beats ≠ 0.
- Framing:
  - A beat carries SOP when its in-packet index is 0.
  - A beat carries EOP when the index is pkt_len−1 or it is the final beat. A truncated last packet therefore still ends with EOP.
  - The index resets to 0 on start and after each EOP beat.
- Data patterns. On start, lane i = i and the beat index = 0.
  - Ramp: after each accepted beat, every lane += NR_LANES, wrapping modulo 2^SAMP_W.
  - Constant: every lane = const_val.
  - Beat index: every lane = beat index [SAMP_W-1:0].
- beats_sent:
  - clears on start and increments on each accepted beat, wrapping at 2^32 in continuous mode;
  - holds its value after the run ends.

## Timing
- All outputs are registered.
- Reset values:
  - valid, sop, eop, readdata = 0; data = lane i = i;
  - state IDLE; all registers and counters 0.
- Reset mid-run returns to IDLE on the next edge, with no EOP emitted.
- Start written at cycle T: internal pulse at T+1, valid = 1 at T+2 carrying beat 0 with SOP.
- While valid = 1 and ready = 0, data, sop and eop are held stable and valid stays 1.
- With gap = 0 and ready held high: one beat per cycle, no bubbles.
- With gap = G: G cycles of valid = 0 between accepted beats.
- busy (status bit0) equals state ≠ IDLE and is visible on the read issued in the cycle after the update.

## Test plan
- Ramp, SAMP_W=16, DATA_W=256, pkt_len=4, total=8, gap=0, ready=1 → exactly 8 beats. SOP on beats 0 and 4, EOP on beats 3 and 7. Beat 1 lane 0 = 16, beat 7 lane 15 = 127. busy = 0 afterwards, beats_sent = 8.
- Truncation: pkt_len=3, total=7 → EOP on beats 2, 5 and 6. SOP on beats 0, 3 and 6 (beat 6 carries both).
- Backpressure: random ready (50%), constant mode with const_val=0xBEEF → every lane is 0xBEEF. Payload and SOP/EOP stay stable while stalled. 20 beats accepted for total=20.
- Gap=3, beat-index mode, ready=1 → 3 idle cycles between beats; lane values run 0, 1, 2, …
- Continuous run with pkt_len=5; stop written mid-packet → stream ends on the next EOP. Packet count is whole; stop_pending is set then clears; a second start restarts from lane i = i.
- Reset asserted during SEND with ready=0 → valid drops on the next edge. Read back: mode = 0, beats_sent = 0, ID = 0xa51579e3, address 12 returns 0xdeadbeef.

Source files
------------

// File: rtl/avalon_st_pattern_gen.sv
// Avalon-ST pattern generator with Avalon-MM control: ramp, constant and
// beat-index lane patterns, SOP/EOP framing, gap throttling and graceful stop.
module avalon_st_pattern_gen #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned SAMP_W = 16
) (
  input  logic              csi_clk_clk,
  input  logic              rsi_reset_reset,
  input  logic [3:0]        avs_ctrl_address,
  input  logic              avs_ctrl_read,
  input  logic              avs_ctrl_write,
  output logic [31:0]       avs_ctrl_readdata,
  input  logic [31:0]       avs_ctrl_writedata,
  output logic [DATA_W-1:0] aso_data_data,
  output logic              aso_data_valid,
  input  logic              aso_data_ready,
  output logic              aso_data_startofpacket,
  output logic              aso_data_endofpacket
);
  localparam int unsigned NR_LANES = DATA_W / SAMP_W;
  localparam logic [31:0] ID_VAL   = 32'ha51579e3;
  localparam logic [31:0] VER_VAL  = 32'h00000300;
  localparam logic [31:0] BAD_VAL  = 32'hdeadbeef;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_t;

  // Builds one beat: mode 1 constant, mode 2 beat index, otherwise ramp from base.
  function automatic logic [DATA_W-1:0] make_beat(input logic [1:0] mode,
                                                  input logic [SAMP_W-1:0] base,
                                                  input logic [SAMP_W-1:0] cval,
                                                  input logic [SAMP_W-1:0] bidx);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < NR_LANES; i++) begin
      case (mode)
        2'd1:    d[i*SAMP_W +: SAMP_W] = cval;
        2'd2:    d[i*SAMP_W +: SAMP_W] = bidx;
        default: d[i*SAMP_W +: SAMP_W] = base + SAMP_W'(i);
      endcase
    end
    return d;
  endfunction

  localparam logic [DATA_W-1:0] INIT_DATA = make_beat(2'd0, '0, '0, '0);

  state_t              state_q;
  logic                start_q, stop_q, stop_pending_q;
  logic [31:0]         scratch_q, pkt_len_q, total_q;
  logic [1:0]          mode_q, w_mode_q;
  logic [7:0]          gap_q, w_gap_q, gap_cnt_q;
  logic [SAMP_W-1:0]   const_q, w_const_q, base_q;
  logic [31:0]         w_pkt_len_q, w_total_q, beats_sent_q, idx_q;
  logic [31:0]         readdata_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q, sop_q, eop_q, last_q;

  logic [31:0]         plen_cfg_d, w_plen_d, sent_nx_d, idx_nx_d, rd_mux_d;
  logic                start_eop_d, start_last_d, last_nx_d, eop_nx_d;
  logic [SAMP_W-1:0]   base_nx_d;
  logic [DATA_W-1:0]   start_data_d, next_data_d;

  // First-beat and following-beat framing/payload plus the read mux.
  always_comb begin
    plen_cfg_d   = (pkt_len_q == 32'd0) ? 32'd1 : pkt_len_q;
    w_plen_d     = (w_pkt_len_q == 32'd0) ? 32'd1 : w_pkt_len_q;
    start_last_d = (total_q == 32'd1);
    start_eop_d  = (plen_cfg_d == 32'd1) || start_last_d;
    start_data_d = make_beat(mode_q, '0, const_q, '0);
    sent_nx_d    = beats_sent_q + 32'd1;
    idx_nx_d     = eop_q ? 32'd0 : idx_q + 32'd1;
    last_nx_d    = (w_total_q != 32'd0) && (sent_nx_d + 32'd1 == w_total_q);
    eop_nx_d     = (idx_nx_d == w_plen_d - 32'd1) || last_nx_d;
    base_nx_d    = base_q + SAMP_W'(NR_LANES);
    next_data_d  = make_beat(w_mode_q, base_nx_d, w_const_q, SAMP_W'(sent_nx_d));
    case (avs_ctrl_address)
      4'd0:    rd_mux_d = ID_VAL;
      4'd1:    rd_mux_d = VER_VAL;
      4'd2:    rd_mux_d = 32'(DATA_W);
      4'd3:    rd_mux_d = scratch_q;
      4'd4:    rd_mux_d = {30'd0, stop_pending_q, state_q != ST_IDLE};
      4'd5:    rd_mux_d = 32'd0;
      4'd6:    rd_mux_d = 32'(mode_q);
      4'd7:    rd_mux_d = pkt_len_q;
      4'd8:    rd_mux_d = total_q;
      4'd9:    rd_mux_d = beats_sent_q;
      4'd10:   rd_mux_d = 32'(gap_q);
      4'd11:   rd_mux_d = 32'(const_q);
      default: rd_mux_d = BAD_VAL;
    endcase
  end

  // Register file, control pulses and the IDLE/SEND/GAP sequencer.
  always_ff @(posedge csi_clk_clk) begin
    if (rsi_reset_reset) begin
      state_q        <= ST_IDLE;
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      stop_pending_q <= 1'b0;
      scratch_q      <= '0;
      mode_q         <= '0;
      pkt_len_q      <= '0;
      total_q        <= '0;
      gap_q          <= '0;
      const_q        <= '0;
      w_mode_q       <= '0;
      w_pkt_len_q    <= '0;
      w_total_q      <= '0;
      w_gap_q        <= '0;
      w_const_q      <= '0;
      gap_cnt_q      <= '0;
      base_q         <= '0;
      beats_sent_q   <= '0;
      idx_q          <= '0;
      readdata_q     <= '0;
      data_q         <= INIT_DATA;
      valid_q        <= 1'b0;
      sop_q          <= 1'b0;
      eop_q          <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      start_q    <= avs_ctrl_write && (avs_ctrl_address == 4'd5) && avs_ctrl_writedata[0];
      stop_q     <= avs_ctrl_write && (avs_ctrl_address == 4'd5) && avs_ctrl_writedata[1];
      readdata_q <= avs_ctrl_read ? rd_mux_d : 32'd0;
      if (avs_ctrl_write) begin
        case (avs_ctrl_address)
          4'd3:    scratch_q <= avs_ctrl_writedata;
          4'd6:    mode_q    <= avs_ctrl_writedata[1:0];
          4'd7:    pkt_len_q <= avs_ctrl_writedata;
          4'd8:    total_q   <= avs_ctrl_writedata;
          4'd10:   gap_q     <= avs_ctrl_writedata[7:0];
          4'd11:   const_q   <= SAMP_W'(avs_ctrl_writedata);
          default: ;
        endcase
      end
      case (state_q)
        ST_IDLE: begin
          if (start_q) begin
            state_q        <= ST_SEND;
            w_mode_q       <= mode_q;
            w_pkt_len_q    <= pkt_len_q;
            w_total_q      <= total_q;
            w_gap_q        <= gap_q;
            w_const_q      <= const_q;
            beats_sent_q   <= '0;
            idx_q          <= '0;
            base_q         <= '0;
            stop_pending_q <= 1'b0;
            data_q         <= start_data_d;
            valid_q        <= 1'b1;
            sop_q          <= 1'b1;
            eop_q          <= start_eop_d;
            last_q         <= start_last_d;
          end
        end
        ST_SEND: begin
          if (stop_q) stop_pending_q <= 1'b1;
          if (aso_data_ready) begin
            beats_sent_q <= sent_nx_d;
            if (last_q || (eop_q && stop_pending_q)) begin
              state_q        <= ST_IDLE;
              valid_q        <= 1'b0;
              sop_q          <= 1'b0;
              eop_q          <= 1'b0;
              last_q         <= 1'b0;
              stop_pending_q <= 1'b0;
            end else begin
              idx_q  <= idx_nx_d;
              base_q <= base_nx_d;
              data_q <= next_data_d;
              sop_q  <= (idx_nx_d == 32'd0);
              eop_q  <= eop_nx_d;
              last_q <= last_nx_d;
              if (w_gap_q != 8'd0) begin
                state_q   <= ST_GAP;
                valid_q   <= 1'b0;
                gap_cnt_q <= w_gap_q;
              end
            end
          end
        end
        ST_GAP: begin
          if (stop_q) stop_pending_q <= 1'b1;
          gap_cnt_q <= gap_cnt_q - 8'd1;
          if (gap_cnt_q == 8'd1) begin
            state_q <= ST_SEND;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign avs_ctrl_readdata      = readdata_q;
  assign aso_data_data          = data_q;
  assign aso_data_valid         = valid_q;
  assign aso_data_startofpacket = sop_q;
  assign aso_data_endofpacket   = eop_q;

endmodule

// File: tb/tb_avalon_st_pattern_gen.sv
// Scoreboard bench for avalon_st_pattern_gen: expected beats and read data are
// queued by the stimulus, a negedge monitor pops and compares.
module tb_avalon_st_pattern_gen;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned SAMP_W = 16;
  localparam int unsigned NR_LANES = DATA_W / SAMP_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        addr = '0;
  logic              rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0]       rdata, wdata = '0;
  logic [DATA_W-1:0] data;
  logic              valid, ready = 1'b0, sop, eop;

  avalon_st_pattern_gen #(.DATA_W(DATA_W), .SAMP_W(SAMP_W)) dut (
    .csi_clk_clk(clk), .rsi_reset_reset(rst),
    .avs_ctrl_address(addr), .avs_ctrl_read(rd_en), .avs_ctrl_write(wr_en),
    .avs_ctrl_readdata(rdata), .avs_ctrl_writedata(wdata),
    .aso_data_data(data), .aso_data_valid(valid), .aso_data_ready(ready),
    .aso_data_startofpacket(sop), .aso_data_endofpacket(eop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] rd_q[$];
  logic [3:0]  rda_q[$];
  int total_cnt = 0, bad_cnt = 0;
  int cyc = 0;
  logic rdy_rand = 1'b0, rdy_fix = 1'b0;
  logic chk_en = 1'b0, rd_pend = 1'b0, prev_stall = 1'b0;
  logic [DATA_W-1:0] p_data;
  logic p_sop, p_eop;
  int spacing = 0, last_cyc = 0;
  logic have_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready: fixed level or 50% random.
  always @(posedge clk) begin
    #1;
    ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  // Monitor: read data, accepted beats, stall stability and gap spacing.
  always @(negedge clk) begin
    if (rd_pend) begin
      logic [31:0] e; logic [3:0] a;
      total_cnt++;
      if (rd_q.size() == 0) begin
        bad_cnt++; $display("FAIL read: no expected value queued, got %h", rdata);
      end else begin
        e = rd_q.pop_front(); a = rda_q.pop_front();
        if (rdata !== e) begin
          bad_cnt++; $display("FAIL read addr %0d: got %h required %h", a, rdata, e);
        end
      end
    end
    rd_pend = rd_en;
    if (!rst && valid && ready) begin
      beat_t b;
      total_cnt++;
      if (exp_q.size() == 0) begin
        bad_cnt++; $display("FAIL beat: unexpected beat data=%h sop=%b eop=%b", data, sop, eop);
      end else begin
        b = exp_q.pop_front();
        if (data !== b.data || sop !== b.sop || eop !== b.eop) begin
          bad_cnt++;
          $display("FAIL beat: got data=%h sop=%b eop=%b required data=%h sop=%b eop=%b",
                   data, sop, eop, b.data, b.sop, b.eop);
        end
      end
      if (spacing != 0 && have_last) begin
        total_cnt++;
        if (cyc - last_cyc != spacing) begin
          bad_cnt++; $display("FAIL gap spacing: got %0d cycles required %0d", cyc - last_cyc, spacing);
        end
      end
      last_cyc = cyc; have_last = 1'b1;
    end
    if (chk_en && prev_stall) begin
      total_cnt++;
      if (valid !== 1'b1 || data !== p_data || sop !== p_sop || eop !== p_eop) begin
        bad_cnt++;
        $display("FAIL stall hold: got valid=%b sop=%b eop=%b data=%h required valid=1 sop=%b eop=%b data=%h",
                 valid, sop, eop, data, p_sop, p_eop, p_data);
      end
    end
    prev_stall = chk_en && valid && !ready;
    p_data = data; p_sop = sop; p_eop = eop;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    addr = a; rd_en = 1'b1; rd_q.push_back(e); rda_q.push_back(a);
    step();
    rd_en = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] m, input int plen, input int tot, input int g, input logic [15:0] cv);
    wr(4'd6, 32'(m)); wr(4'd7, 32'(plen)); wr(4'd8, 32'(tot));
    wr(4'd10, 32'(g)); wr(4'd11, 32'(cv));
  endtask

  // Expected lanes: kind 0 ramp, 1 constant, 2 beat index.
  function automatic logic [DATA_W-1:0] lanes(input int kind, input int b, input logic [15:0] cv);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < int'(NR_LANES); i++) begin
      if (kind == 1)      d[i*SAMP_W +: SAMP_W] = cv;
      else if (kind == 2) d[i*SAMP_W +: SAMP_W] = 16'(b);
      else                d[i*SAMP_W +: SAMP_W] = 16'(b * 16 + i);
    end
    return d;
  endfunction

  task automatic push_run(input int kind, input int n, input int plen, input logic [15:0] cv);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = lanes(kind, k, cv);
      b.sop  = (k % plen) == 0;
      b.eop  = ((k % plen) == plen - 1) || (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    total_cnt++;
    if (exp_q.size() != 0) begin
      bad_cnt++; $display("FAIL drain %s: %0d beats left required 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (4) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (valid !== 1'b0 || sop !== 1'b0 || eop !== 1'b0 || data !== lanes(0, 0, 16'h0)) begin
      bad_cnt++; $display("FAIL reset outputs: valid=%b sop=%b eop=%b data=%h required 0 0 0 ramp lane i=i",
                          valid, sop, eop, data);
    end
    step();
    chk_en = 1'b1;
    rd(4'd0, 32'ha51579e3);
    rd(4'd1, 32'h00000300);
    rd(4'd2, 32'd256);
    rd(4'd3, 32'h0);
    rd(4'd4, 32'h0);
    wr(4'd3, 32'h12345678);
    rd(4'd3, 32'h12345678);
    rd(4'd15, 32'hdeadbeef);

    // Ramp, 2 packets of 4.
    rdy_fix = 1'b1;
    cfg(2'd0, 4, 8, 0, 16'h0);
    push_run(0, 8, 4, 16'h0);
    wr(4'd5, 32'h1);
    wait_drain(60, "ramp");
    rd(4'd4, 32'h0);
    rd(4'd9, 32'd8);

    // Truncated last packet.
    cfg(2'd0, 3, 7, 0, 16'h0);
    push_run(0, 7, 3, 16'h0);
    wr(4'd5, 32'h1);
    wait_drain(60, "trunc");

    // Constant pattern under random backpressure.
    rdy_rand = 1'b1;
    cfg(2'd1, 4, 20, 0, 16'hBEEF);
    push_run(1, 20, 4, 16'hBEEF);
    wr(4'd5, 32'h1);
    wait_drain(400, "backpressure");
    rdy_rand = 1'b0;
    rd(4'd9, 32'd20);

    // Gap of 3, beat-index pattern.
    cfg(2'd2, 2, 5, 3, 16'h0);
    push_run(2, 5, 2, 16'h0);
    spacing = 4; have_last = 1'b0;
    wr(4'd5, 32'h1);
    wait_drain(100, "gap");
    spacing = 0;

    // Continuous run, stop mid-packet: stop lands before beat 7, run ends on beat 9.
    cfg(2'd0, 5, 0, 0, 16'h0);
    push_run(0, 10, 5, 16'h0);
    wr(4'd5, 32'h1);
    repeat (6) step();
    wr(4'd5, 32'h2);
    step();
    rd(4'd4, 32'h3);
    wait_drain(60, "stop");
    rd(4'd4, 32'h0);
    rd(4'd9, 32'd10);
    wr(4'd8, 32'd3);
    push_run(0, 3, 5, 16'h0);
    wr(4'd5, 32'h3);
    wait_drain(60, "restart");
    rd(4'd9, 32'd3);

    // Reset while stalled in SEND.
    rdy_fix = 1'b0;
    repeat (2) step();
    cfg(2'd1, 4, 0, 0, 16'h1234);
    wr(4'd5, 32'h1);
    begin
      int n = 0;
      while (valid !== 1'b1 && n < 20) begin step(); n++; end
      total_cnt++;
      if (valid !== 1'b1) begin bad_cnt++; $display("FAIL start timeout: valid=%b required 1", valid); end
    end
    repeat (3) step();
    chk_en = 1'b0;
    rst = 1'b1;
    step();
    total_cnt++;
    if (valid !== 1'b0 || eop !== 1'b0) begin
      bad_cnt++; $display("FAIL reset mid-run: valid=%b eop=%b required 0 0", valid, eop);
    end
    rst = 1'b0;
    step();
    chk_en = 1'b1;
    rd(4'd6, 32'h0);
    rd(4'd9, 32'h0);
    rd(4'd0, 32'ha51579e3);
    rd(4'd12, 32'hdeadbeef);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
